// File: rtl/iter_alu_if.sv
// Request/response bundle for iter_alu: valid/ready request carrying op and
// operands, valid/ready response carrying the result and its status flags.
interface iter_alu_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] val1;
  logic [WIDTH-1:0] val2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             div_by_zero;
  logic             illegal_op;

  modport master (
    output in_valid, op, val1, val2, out_ready,
    input  in_ready, out_valid, result, div_by_zero, illegal_op
  );

  modport slave (
    input  in_valid, op, val1, val2, out_ready,
    output in_ready, out_valid, result, div_by_zero, illegal_op
  );
endinterface

// File: rtl/iter_alu.sv
// Small ALU: single-cycle add/sub/shift/sign ops plus bit-serial multiply and
// restoring unsigned divide/remainder, behind a one-deep valid/ready pipeline.
module iter_alu #(
  parameter  int WIDTH   = 32,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input logic        clk,
  input logic        rstn,
  iter_alu_if.slave  bus
);

  localparam logic [3:0] OP_ADD    = 4'd0;
  localparam logic [3:0] OP_SUB    = 4'd1;
  localparam logic [3:0] OP_SLL    = 4'd2;
  localparam logic [3:0] OP_SRL    = 4'd3;
  localparam logic [3:0] OP_SRA    = 4'd4;
  localparam logic [3:0] OP_FISPOS = 4'd5;
  localparam logic [3:0] OP_FISNEG = 4'd6;
  localparam logic [3:0] OP_FNEG   = 4'd7;
  localparam logic [3:0] OP_MUL    = 4'd8;
  localparam logic [3:0] OP_DIVU   = 4'd9;
  localparam logic [3:0] OP_REMU   = 4'd10;

  localparam logic [SHAMT_W-1:0] CNT_LAST = SHAMT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state_reg;
  logic [SHAMT_W-1:0] cnt_reg;
  logic [3:0]         op_reg;
  logic [WIDTH-1:0]   acc_reg;   // MUL: partial product, DIV: partial remainder
  logic [WIDTH-1:0]   aux_reg;   // MUL: multiplier, DIV: dividend -> quotient
  logic [WIDTH-1:0]   opnd_reg;  // MUL: shifted multiplicand, DIV: divisor
  logic               dz_pend_reg;
  logic               out_valid_reg;
  logic [WIDTH-1:0]   result_reg;
  logic               dz_reg;
  logic               ill_reg;

  logic               accept;
  logic               is_iter;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   quick_res;
  logic               quick_ill;
  logic [WIDTH-1:0]   mul_sum;
  logic [WIDTH:0]     rem_shift;
  logic               rem_ge;
  logic [WIDTH-1:0]   rem_next;
  logic [WIDTH-1:0]   quo_next;

  assign bus.in_ready    = (state_reg == IDLE) || (state_reg == DONE && bus.out_ready);
  assign bus.out_valid   = out_valid_reg;
  assign bus.result      = result_reg;
  assign bus.div_by_zero = dz_reg;
  assign bus.illegal_op  = ill_reg;

  assign accept  = bus.in_valid && bus.in_ready;
  assign is_iter = (bus.op == OP_MUL) || (bus.op == OP_DIVU) || (bus.op == OP_REMU);
  assign shamt   = bus.val2[SHAMT_W-1:0];

  always_comb begin
    quick_res = '0;
    quick_ill = 1'b0;
    case (bus.op)
      OP_ADD:    quick_res = bus.val1 + bus.val2;
      OP_SUB:    quick_res = bus.val1 - bus.val2;
      OP_SLL:    quick_res = bus.val1 << shamt;
      OP_SRL:    quick_res = bus.val1 >> shamt;
      OP_SRA:    quick_res = $unsigned($signed(bus.val1) >>> shamt);
      OP_FISPOS: quick_res = {{(WIDTH-1){1'b0}}, ~bus.val2[WIDTH-1]};
      OP_FISNEG: quick_res = {{(WIDTH-1){1'b0}}, bus.val2[WIDTH-1]};
      OP_FNEG:   quick_res = {~bus.val2[WIDTH-1], bus.val2[WIDTH-2:0]};
      OP_MUL, OP_DIVU, OP_REMU: quick_res = '0;
      default:   quick_ill = 1'b1;
    endcase
  end

  // One bit per cycle. A zero divisor needs no special path: every trial
  // subtract succeeds, giving an all-ones quotient and remainder == dividend.
  assign mul_sum   = acc_reg + (aux_reg[0] ? opnd_reg : '0);
  assign rem_shift = {acc_reg, aux_reg[WIDTH-1]};
  assign rem_ge    = rem_shift >= {1'b0, opnd_reg};
  assign rem_next  = rem_ge ? (rem_shift[WIDTH-1:0] - opnd_reg) : rem_shift[WIDTH-1:0];
  assign quo_next  = {aux_reg[WIDTH-2:0], rem_ge};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      op_reg        <= '0;
      acc_reg       <= '0;
      aux_reg       <= '0;
      opnd_reg      <= '0;
      dz_pend_reg   <= 1'b0;
      out_valid_reg <= 1'b0;
      result_reg    <= '0;
      dz_reg        <= 1'b0;
      ill_reg       <= 1'b0;
    end else if (accept) begin
      // Reached from IDLE, or from DONE while the current result retires.
      op_reg  <= bus.op;
      cnt_reg <= '0;
      if (is_iter) begin
        state_reg     <= BUSY;
        out_valid_reg <= 1'b0;
        acc_reg       <= '0;
        aux_reg       <= (bus.op == OP_MUL) ? bus.val2 : bus.val1;
        opnd_reg      <= (bus.op == OP_MUL) ? bus.val1 : bus.val2;
        dz_pend_reg   <= (bus.op != OP_MUL) && (bus.val2 == '0);
      end else begin
        state_reg     <= DONE;
        out_valid_reg <= 1'b1;
        result_reg    <= quick_res;
        dz_reg        <= 1'b0;
        ill_reg       <= quick_ill;
      end
    end else begin
      case (state_reg)
        BUSY: begin
          cnt_reg <= cnt_reg + SHAMT_W'(1);
          if (op_reg == OP_MUL) begin
            acc_reg  <= mul_sum;
            aux_reg  <= aux_reg >> 1;
            opnd_reg <= opnd_reg << 1;
          end else begin
            acc_reg <= rem_next;
            aux_reg <= quo_next;
          end
          if (cnt_reg == CNT_LAST) begin
            state_reg     <= DONE;
            out_valid_reg <= 1'b1;
            dz_reg        <= dz_pend_reg;
            ill_reg       <= 1'b0;
            if (op_reg == OP_MUL)
              result_reg <= mul_sum;
            else if (op_reg == OP_DIVU)
              result_reg <= quo_next;
            else
              result_reg <= rem_next;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
